// File: rtl/pipeline_multi_4in_32bit.sv
// Four-operand 32-bit unsigned multiplier, 4-stage pipeline, exact 128-bit product.
// Define PIPE_VALID_EN to add an in_valid/out_valid tag that travels with the data.
module pipeline_multi_4in_32bit (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  g_InA0,
  input  logic [31:0]  g_InA1,
  input  logic [31:0]  g_InA2,
  input  logic [31:0]  g_InA3,
`ifdef PIPE_VALID_EN
  input  logic         in_valid,
  output logic         out_valid,
`endif
  output logic [127:0] g_outM
);

  logic [31:0]  a0_q, a1_q, a2_q, a3_q;
  logic [31:0]  a0_d, a1_d, a2_d, a3_d;
  logic [63:0]  p01_q, p23_q, p01_d, p23_d;
  logic [63:0]  ll_q, lh_q, hl_q, hh_q;
  logic [63:0]  ll_d, lh_d, hl_d, hh_d;
  logic [64:0]  mid;
  logic [127:0] outm_q, outm_d;

  always_comb begin
    a0_d  = g_InA0;
    a1_d  = g_InA1;
    a2_d  = g_InA2;
    a3_d  = g_InA3;
    p01_d = 64'(a0_q) * 64'(a1_q);
    p23_d = 64'(a2_q) * 64'(a3_q);
    ll_d  = 64'(p01_q[31:0])  * 64'(p23_q[31:0]);
    lh_d  = 64'(p01_q[31:0])  * 64'(p23_q[63:32]);
    hl_d  = 64'(p01_q[63:32]) * 64'(p23_q[31:0]);
    hh_d  = 64'(p01_q[63:32]) * 64'(p23_q[63:32]);
    // The middle sum can carry into bit 64, so it is kept at 65 bits before the shift.
    mid    = {1'b0, lh_q} + {1'b0, hl_q};
    outm_d = {hh_q, 64'd0} + {31'd0, mid, 32'd0} + {64'd0, ll_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a0_q   <= '0;
      a1_q   <= '0;
      a2_q   <= '0;
      a3_q   <= '0;
      p01_q  <= '0;
      p23_q  <= '0;
      ll_q   <= '0;
      lh_q   <= '0;
      hl_q   <= '0;
      hh_q   <= '0;
      outm_q <= '0;
    end else begin
      a0_q   <= a0_d;
      a1_q   <= a1_d;
      a2_q   <= a2_d;
      a3_q   <= a3_d;
      p01_q  <= p01_d;
      p23_q  <= p23_d;
      ll_q   <= ll_d;
      lh_q   <= lh_d;
      hl_q   <= hl_d;
      hh_q   <= hh_d;
      outm_q <= outm_d;
    end
  end

  assign g_outM = outm_q;

`ifdef PIPE_VALID_EN
  logic [3:0] vld_q, vld_d;

  always_comb begin
    vld_d = {vld_q[2:0], in_valid};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_d;
  end

  assign out_valid = vld_q[3];
`endif

endmodule

// File: tb/tb_pipeline_multi_4in_32bit.sv
// Self-checking bench for pipeline_multi_4in_32bit: directed vectors plus a
// history-based product model compared every cycle after the first reset.
module tb_pipeline_multi_4in_32bit;

  logic         clk;
  logic         rst_n;
  logic [31:0]  inA0, inA1, inA2, inA3;
  logic         inVld;
  logic [127:0] outM;
`ifdef PIPE_VALID_EN
  logic         outVld;
`endif

  int passCount;
  int checkCount;

  // Model state: what was presented at each rising edge, indexed by edge number.
  logic [127:0] histProd [0:1023];
  logic         histRst  [0:1023];
  logic         histVld  [0:1023];
  int           edgeCnt;
  int           firstRst;

  pipeline_multi_4in_32bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .g_InA0    (inA0),
    .g_InA1    (inA1),
    .g_InA2    (inA2),
    .g_InA3    (inA3),
`ifdef PIPE_VALID_EN
    .in_valid  (inVld),
    .out_valid (outVld),
`endif
    .g_outM    (outM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record each edge's sampled operands as a plain 128-bit product.
  always @(posedge clk) begin
    if (edgeCnt < 1024) begin
      histProd[edgeCnt] = 128'(inA0) * 128'(inA1) * 128'(inA2) * 128'(inA3);
      histRst[edgeCnt]  = rst_n;
      histVld[edgeCnt]  = inVld;
      if (!rst_n && firstRst < 0) firstRst = edgeCnt;
    end
    edgeCnt = edgeCnt + 1;
  end

  // Output after edge k is the set sampled at edge k-3, unless a reset edge lies in k-3..k.
  always @(negedge clk) begin
    int k;
    logic [127:0] expM;
    logic expV;
    logic flushed;
    k = edgeCnt - 1;
    if (firstRst >= 0 && k >= firstRst && k < 1024) begin
      flushed = 1'b0;
      for (int j = k - 3; j <= k; j++)
        if (j >= 0 && !histRst[j]) flushed = 1'b1;
      expM = flushed ? 128'd0 : histProd[k-3];
      expV = flushed ? 1'b0 : histVld[k-3];
      checkCount = checkCount + 1;
      if (outM === expM) passCount = passCount + 1;
      else $display("[TB] FAIL model_edge%0d: g_outM=%h required=%h", k, outM, expM);
`ifdef PIPE_VALID_EN
      checkCount = checkCount + 1;
      if (outVld === expV) passCount = passCount + 1;
      else $display("[TB] FAIL model_valid_edge%0d: out_valid=%b required=%b", k, outVld, expV);
`else
      if (expV === 1'bx) $display("[TB] note: unknown in_valid history at edge %0d", k);
`endif
    end
  end

  task automatic applyStimulus(input logic [31:0] x0, input logic [31:0] x1,
                               input logic [31:0] x2, input logic [31:0] x3,
                               input logic rstn, input logic vld);
    @(negedge clk);
    inA0  = x0;
    inA1  = x1;
    inA2  = x2;
    inA3  = x3;
    rst_n = rstn;
    inVld = vld;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [127:0] expM);
    checkCount = checkCount + 1;
    if (outM === expM) passCount = passCount + 1;
    else $display("[TB] FAIL %s: g_outM=%h required=%h", name, outM, expM);
  endtask

`ifdef PIPE_VALID_EN
  task automatic checkValid(input string name, input logic expV);
    checkCount = checkCount + 1;
    if (outVld === expV) passCount = passCount + 1;
    else $display("[TB] FAIL %s: out_valid=%b required=%b", name, outVld, expV);
  endtask
`endif

  initial begin
    passCount  = 0;
    checkCount = 0;
    edgeCnt    = 0;
    firstRst   = -1;
    rst_n = 1'b0;
    inA0 = '0; inA1 = '0; inA2 = '0; inA3 = '0;
    inVld = 1'b0;

    // Basic: reset two cycles, then hold all operands at 2.
    applyStimulus(0, 0, 0, 0, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 0, 1'b0, 1'b0);
    checkOutput("reset_state", 128'd0);
`ifdef PIPE_VALID_EN
    checkValid("reset_valid", 1'b0);
`endif
    applyStimulus(2, 2, 2, 2, 1'b1, 1'b0);
    checkOutput("post_reset_t0", 128'd0);
    for (int i = 1; i <= 3; i++) begin
      waitCycles(1);
      checkOutput($sformatf("post_reset_t%0d", i), 128'd0);
    end
    for (int i = 0; i < 3; i++) begin
      waitCycles(1);
      checkOutput($sformatf("basic_16_%0d", i), 128'd16);
    end

    // Back-to-back sets.
    applyStimulus(1, 2, 3, 4, 1'b1, 1'b0);
    checkOutput("b2b_prev", 128'd16);
    applyStimulus(5, 6, 7, 8, 1'b1, 1'b0);
    applyStimulus(0, 9, 9, 9, 1'b1, 1'b0);
    waitCycles(2);
    checkOutput("b2b_24", 128'd24);
    waitCycles(1);
    checkOutput("b2b_1680", 128'd1680);
    waitCycles(1);
    checkOutput("b2b_zero", 128'd0);

    // Maximum operands exercise the middle-term carry.
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    waitCycles(4);
    checkOutput("max", 128'hFFFFFFFC_00000005_FFFFFFFC_00000001);

    // Product crossing the 64-bit boundary.
    applyStimulus(32'h80000000, 32'd2, 32'h10000, 32'h10000, 1'b1, 1'b0);
    waitCycles(4);
    checkOutput("cross_half", 128'h1_0000_0000_0000_0000);

    // Random stream, one-cycle reset mid-stream, then resume.
    for (int i = 0; i < 10; i++)
      applyStimulus($urandom, $urandom, $urandom, $urandom, 1'b1, 1'b0);
    applyStimulus($urandom, $urandom, $urandom, $urandom, 1'b0, 1'b0);
    applyStimulus($urandom, $urandom, $urandom, $urandom, 1'b1, 1'b0);
    checkOutput("midstream_flush", 128'd0);
    for (int i = 0; i < 12; i++)
      applyStimulus($urandom, $urandom, $urandom, $urandom, 1'b1, 1'b0);
    applyStimulus(0, 0, 0, 0, 1'b1, 1'b0);
    waitCycles(4);
    checkOutput("zero_drain", 128'd0);

`ifdef PIPE_VALID_EN
    // Single valid pulse travels with its data.
    applyStimulus(3, 3, 3, 3, 1'b1, 1'b1);
    applyStimulus(3, 3, 3, 3, 1'b1, 1'b0);
    checkValid("vld_t1", 1'b0);
    waitCycles(2);
    checkValid("vld_t3", 1'b0);
    waitCycles(1);
    checkValid("vld_t4", 1'b1);
    checkOutput("vld_data_81", 128'd81);
    waitCycles(1);
    checkValid("vld_t5", 1'b0);
    applyStimulus(3, 3, 3, 3, 1'b1, 1'b1);
    applyStimulus(3, 3, 3, 3, 1'b0, 1'b1);
    applyStimulus(3, 3, 3, 3, 1'b1, 1'b0);
    checkValid("vld_after_reset", 1'b0);
    waitCycles(5);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
